// File: rtl/slot_sequencer.sv
// Walks the per-slot register bank, issues one command per PENDING slot and writes the result status back.
// Optional completion watchdog: define SLOT_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// SCAN      | examine slot idx: skip, reject (size 0) or latch command
// ISSUE     | cmd_valid held with stable cmd_* until cmd_ready
// WAIT      | waiting for the completion strobe (or watchdog expiry)
// WRITEBACK | wb_set_status pulse visible, err_count update, advance
// FINISH    | last slot handled, done pulse issued on exit
module slot_sequencer #(
  parameter int NUM_SLOTS       = 2,
  parameter int INPUT_IDX_WIDTH = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 26,
  parameter int STATUS_WIDTH    = 2,
  parameter int PROFILE_WIDTH   = 4,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]     slot_addr_flat,
  input  logic [NUM_SLOTS*SIZE_WIDTH-1:0]     slot_size_flat,
  input  logic [NUM_SLOTS*STATUS_WIDTH-1:0]   slot_status_flat,
  input  logic [NUM_SLOTS*PROFILE_WIDTH-1:0]  slot_profile_flat,
  output logic                                cmd_valid,
  input  logic                                cmd_ready,
  output logic [ADDR_WIDTH-1:0]               cmd_addr,
  output logic [SIZE_WIDTH-1:0]               cmd_size,
  output logic [PROFILE_WIDTH-1:0]            cmd_profile,
  input  logic                                cmp_valid,
  input  logic                                cmp_err,
  output logic [INPUT_IDX_WIDTH-1:0]          wb_idx,
  output logic [STATUS_WIDTH-1:0]             wb_status,
  output logic                                wb_set_status,
  output logic                                busy,
  output logic                                done,
  output logic [7:0]                          err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_WRITEBACK,
    S_FINISH
  } state_t;

  localparam logic [STATUS_WIDTH-1:0]    ST_PENDING = STATUS_WIDTH'(1);
  localparam logic [STATUS_WIDTH-1:0]    ST_DONE    = STATUS_WIDTH'(2);
  localparam logic [STATUS_WIDTH-1:0]    ST_ERROR   = STATUS_WIDTH'(3);
  localparam logic [INPUT_IDX_WIDTH-1:0] LAST_IDX   = INPUT_IDX_WIDTH'(NUM_SLOTS - 1);

  state_t                     state;
  logic [INPUT_IDX_WIDTH-1:0] idx;

  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [SIZE_WIDTH-1:0]      sel_size;
  logic [STATUS_WIDTH-1:0]    sel_status;
  logic [PROFILE_WIDTH-1:0]   sel_profile;

`ifdef SLOT_SEQ_TIMEOUT_EN
  // Expiry is taken on the WAIT cycle whose increment would reach all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
`endif

  always_comb begin
    sel_addr    = slot_addr_flat[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_size    = slot_size_flat[int'(idx)*SIZE_WIDTH +: SIZE_WIDTH];
    sel_status  = slot_status_flat[int'(idx)*STATUS_WIDTH +: STATUS_WIDTH];
    sel_profile = slot_profile_flat[int'(idx)*PROFILE_WIDTH +: PROFILE_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      cmd_valid     <= 1'b0;
      cmd_addr      <= '0;
      cmd_size      <= '0;
      cmd_profile   <= '0;
      wb_idx        <= '0;
      wb_status     <= '0;
      wb_set_status <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_count     <= '0;
`ifdef SLOT_SEQ_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      wb_set_status <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            busy      <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (sel_status != ST_PENDING) begin
            if (idx == LAST_IDX) begin
              state <= S_FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SCAN;
            end
          end else if (sel_size == '0) begin
            wb_idx        <= idx;
            wb_status     <= ST_ERROR;
            wb_set_status <= 1'b1;
            state         <= S_WRITEBACK;
          end else begin
            cmd_addr    <= sel_addr;
            cmd_size    <= sel_size;
            cmd_profile <= sel_profile;
            cmd_valid   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
`ifdef SLOT_SEQ_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmp_valid) begin
            wb_idx        <= idx;
            wb_status     <= cmp_err ? ST_ERROR : ST_DONE;
            wb_set_status <= 1'b1;
            state         <= S_WRITEBACK;
          end
`ifdef SLOT_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            to_cnt        <= to_cnt + 1'b1;
            wb_idx        <= idx;
            wb_status     <= ST_ERROR;
            wb_set_status <= 1'b1;
            state         <= S_WRITEBACK;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_WRITEBACK: begin
          if (wb_status == ST_ERROR && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
          if (idx == LAST_IDX) begin
            state <= S_FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_SCAN;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_sequencer.sv
// Directed bench for slot_sequencer: empty pass, normal/error completions, size-0 reject,
// ignored start/cmp_valid, mid-pass reset and (with SLOT_SEQ_TIMEOUT_EN) watchdog expiry.
module tb_slot_sequencer;

`ifdef SLOT_SEQ_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] slot_addr_flat = '0;
  logic [51:0] slot_size_flat = '0;
  logic [3:0]  slot_status_flat = '0;
  logic [7:0]  slot_profile_flat = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [25:0] cmd_size;
  logic [3:0]  cmd_profile;
  logic        cmp_valid = 1'b0;
  logic        cmp_err = 1'b0;
  logic [0:0]  wb_idx;
  logic [1:0]  wb_status;
  logic        wb_set_status;
  logic        busy;
  logic        done;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int wb_cnt = 0;
  int cv_seen = 0;

  slot_sequencer #(
    .NUM_SLOTS(2), .INPUT_IDX_WIDTH(1), .ADDR_WIDTH(32), .SIZE_WIDTH(26),
    .STATUS_WIDTH(2), .PROFILE_WIDTH(4), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .slot_addr_flat(slot_addr_flat), .slot_size_flat(slot_size_flat),
    .slot_status_flat(slot_status_flat), .slot_profile_flat(slot_profile_flat),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_profile(cmd_profile),
    .cmp_valid(cmp_valid), .cmp_err(cmp_err),
    .wb_idx(wb_idx), .wb_status(wb_status), .wb_set_status(wb_set_status),
    .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) hs_cnt++;
    if (wb_set_status) wb_cnt++;
    if (cmd_valid) cv_seen++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [1:0] st, input logic [31:0] a,
                          input logic [25:0] sz, input logic [3:0] pr);
    slot_status_flat[i*2 +: 2]   = st;
    slot_addr_flat[i*32 +: 32]   = a;
    slot_size_flat[i*26 +: 26]   = sz;
    slot_profile_flat[i*4 +: 4]  = pr;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int hs0;
    int wb0;
    // reset values
    #3;
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_addr", cmd_addr, 32'h0);
    chk("rst_wb_set", wb_set_status, 1'b0);
    chk("rst_wb_idx", wb_idx, 1'b0);
    chk("rst_wb_status", wb_status, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // empty pass: done visible in cycle 4 after start
    set_slot(0, 2'd0, 32'h0, 26'h0, 4'h0);
    set_slot(1, 2'd0, 32'h0, 26'h0, 4'h0);
    cv_seen = 0;
    pulse_start();
    chk("empty_busy", busy, 1'b1);
    tick();
    tick();
    chk("empty_done_c3", done, 1'b0);
    tick();
    chk("empty_done_c4", done, 1'b1);
    chk("empty_err_count", err_count, 8'd0);
    chk("empty_no_cmd", cv_seen, 0);
    tick();
    chk("empty_done_drop", done, 1'b0);
    chk("empty_busy_drop", busy, 1'b0);

    // slot0 pending, ready delayed 3 cycles, good completion
    set_slot(0, 2'd1, 32'h1000_0000, 26'h400, 4'h3);
    pulse_start();
    tick();
    chk("p0_cmd_valid", cmd_valid, 1'b1);
    chk("p0_cmd_addr", cmd_addr, 32'h1000_0000);
    chk("p0_cmd_size", cmd_size, 26'h400);
    chk("p0_cmd_profile", cmd_profile, 4'h3);
    set_slot(0, 2'd1, 32'hDEAD_BEEF, 26'h3FF_FFFF, 4'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p0_hold_valid", cmd_valid, 1'b1);
      chk("p0_hold_addr", cmd_addr, 32'h1000_0000);
      chk("p0_hold_size", cmd_size, 26'h400);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("p0_valid_drop", cmd_valid, 1'b0);
    tick();
    chk("p0_no_early_wb", wb_set_status, 1'b0);
    cmp_valid = 1'b1;
    cmp_err = 1'b0;
    tick();
    cmp_valid = 1'b0;
    chk("p0_wb_set", wb_set_status, 1'b1);
    chk("p0_wb_idx", wb_idx, 1'b0);
    chk("p0_wb_status", wb_status, 2'd2);
    tick();
    chk("p0_wb_one_cycle", wb_set_status, 1'b0);
    wait_done("p0_done");
    chk("p0_err_count", err_count, 8'd0);

    // slot0 DONE skipped, slot1 pending with error completion
    set_slot(0, 2'd2, 32'h2000_0000, 26'h10, 4'h1);
    set_slot(1, 2'd1, 32'h3000_0040, 26'h80, 4'h9);
    pulse_start();
    tick();
    chk("p1_skip_no_cmd", cmd_valid, 1'b0);
    tick();
    chk("p1_cmd_valid", cmd_valid, 1'b1);
    chk("p1_cmd_addr", cmd_addr, 32'h3000_0040);
    chk("p1_cmd_profile", cmd_profile, 4'h9);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmp_valid = 1'b1;
    cmp_err = 1'b1;
    tick();
    cmp_valid = 1'b0;
    cmp_err = 1'b0;
    chk("p1_wb_set", wb_set_status, 1'b1);
    chk("p1_wb_idx", wb_idx, 1'b1);
    chk("p1_wb_status", wb_status, 2'd3);
    tick();
    chk("p1_err_count", err_count, 8'd1);
    wait_done("p1_done");

    // slot1 pending with size 0: rejected without a command
    set_slot(0, 2'd0, 32'h0, 26'h0, 4'h0);
    set_slot(1, 2'd1, 32'h4000_0000, 26'h0, 4'h2);
    cv_seen = 0;
    pulse_start();
    chk("z_err_cleared", err_count, 8'd0);
    tick();
    tick();
    chk("z_wb_set", wb_set_status, 1'b1);
    chk("z_wb_idx", wb_idx, 1'b1);
    chk("z_wb_status", wb_status, 2'd3);
    wait_done("z_done");
    chk("z_no_cmd", cv_seen, 0);
    chk("z_err_count", err_count, 8'd1);

    // start in WAIT and cmp_valid in ISSUE are ignored
    set_slot(0, 2'd1, 32'h5000_0000, 26'h20, 4'h4);
    set_slot(1, 2'd1, 32'h6000_0000, 26'h30, 4'h5);
    hs0 = hs_cnt;
    wb0 = wb_cnt;
    pulse_start();
    tick();
    chk("ig_cmd_valid", cmd_valid, 1'b1);
    cmp_valid = 1'b1;
    tick();
    chk("ig_cmp_in_issue", wb_set_status, 1'b0);
    chk("ig_still_valid", cmd_valid, 1'b1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmp_valid = 1'b0;
    chk("ig_cmp_on_hs", wb_set_status, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ig_start_busy", busy, 1'b1);
    chk("ig_start_no_wb", wb_set_status, 1'b0);
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    chk("ig_wb0_idx", wb_idx, 1'b0);
    chk("ig_wb0_status", wb_status, 2'd2);
    tick();
    tick();
    chk("ig_cmd1_addr", cmd_addr, 32'h6000_0000);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    chk("ig_wb1_idx", wb_idx, 1'b1);
    wait_done("ig_done");
    tick();
    tick();
    tick();
    chk("ig_cmd_count", hs_cnt - hs0, 2);
    chk("ig_wb_count", wb_cnt - wb0, 2);
    chk("ig_idle_busy", busy, 1'b0);

    // reset asserted while waiting for completion
    set_slot(1, 2'd0, 32'h0, 26'h0, 4'h0);
    pulse_start();
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("r_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("r_cmd_valid", cmd_valid, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_wb_set", wb_set_status, 1'b0);
    wb0 = wb_cnt;
    @(negedge clk);
    reset = 1'b1;
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    tick();
    tick();
    chk("r_no_wb", wb_cnt - wb0, 0);
    chk("r_idle", busy, 1'b0);

`ifdef SLOT_SEQ_TIMEOUT_EN
    // watchdog: no completion ends WAIT after 15 cycles with ERROR
    pulse_start();
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    wb0 = wb_cnt;
    for (int k = 0; k < 14; k++) tick();
    chk("to_not_yet", wb_set_status, 1'b0);
    tick();
    chk("to_wb_set", wb_set_status, 1'b1);
    chk("to_wb_status", wb_status, 2'd3);
    wait_done("to_done");
    chk("to_err_count", err_count, 8'd1);
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    tick();
    chk("to_late_cmp", wb_cnt - wb0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
